// File: rtl/branch_predict_unit_if.sv
// Fetch-side prediction, EX-side resolution and redirect signals of the branch predict unit.
// master = pipeline side, slave = predictor side.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_pc_plus4;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_srcA;
  logic [XLEN-1:0]  ex_srcB;
  logic [2:0]       ex_funct3;
  logic [6:0]       ex_opcode;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;

  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_pc_plus4, ex_imm, ex_srcA, ex_srcB,
           ex_funct3, ex_opcode, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect, redirect_pc, mispredict_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_pc_plus4, ex_imm, ex_srcA, ex_srcB,
           ex_funct3, ex_opcode, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect, redirect_pc, mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: same-cycle fetch prediction, EX resolution and
// training, registered mispredict redirect and a saturating mispredict counter.
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_predict_unit_if.slave bus
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic            valid_q   [ENTRIES];
  logic [TAGW-1:0] tag_q     [ENTRIES];
  logic [XLEN-1:0] target_q  [ENTRIES];
  logic            is_jump_q [ENTRIES];
  logic [1:0]      ctr_q     [ENTRIES];

  logic             redirect_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] mispredict_cnt_q;

  // Fetch lookup reads the table as it stood before this cycle's edge.
  logic [IDXW-1:0] f_idx;
  logic            f_hit;

  assign f_idx           = bus.if_pc[IDXW+1:2];
  assign f_hit           = valid_q[f_idx] && (tag_q[f_idx] == bus.if_pc[XLEN-1:IDXW+2]);
  assign bus.pred_taken  = f_hit && (is_jump_q[f_idx] || ctr_q[f_idx][1]);
  assign bus.pred_target = bus.pred_taken ? target_q[f_idx] : '0;

  logic [XLEN-1:0] br_sum;
  logic [XLEN-1:0] jr_sum;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            is_ctl;
  logic            is_jmp;

  assign br_sum = bus.ex_pc + bus.ex_imm;
  assign jr_sum = bus.ex_srcA + bus.ex_imm;

  always_comb begin
    taken  = 1'b0;
    target = '0;
    is_ctl = 1'b0;
    is_jmp = 1'b0;
    case (bus.ex_opcode)
      OP_BRANCH: begin
        target = br_sum;
        is_ctl = 1'b1;
        case (bus.ex_funct3)
          3'b000:  taken = (bus.ex_srcA == bus.ex_srcB);
          3'b001:  taken = (bus.ex_srcA != bus.ex_srcB);
          3'b100:  taken = ($signed(bus.ex_srcA) <  $signed(bus.ex_srcB));
          3'b101:  taken = ($signed(bus.ex_srcA) >= $signed(bus.ex_srcB));
          3'b110:  taken = (bus.ex_srcA <  bus.ex_srcB);
          3'b111:  taken = (bus.ex_srcA >= bus.ex_srcB);
          default: is_ctl = 1'b0;
        endcase
      end
      OP_JAL: begin
        taken  = 1'b1;
        target = br_sum;
        is_ctl = 1'b1;
        is_jmp = 1'b1;
      end
      OP_JALR: begin
        taken  = 1'b1;
        target = {jr_sum[XLEN-1:1], 1'b0};
        is_ctl = 1'b1;
        is_jmp = 1'b1;
      end
      default: ;
    endcase
  end

  logic            mispredict;
  logic            update;
  logic [IDXW-1:0] e_idx;
  logic [TAGW-1:0] e_tag;
  logic            e_hit;

  assign mispredict = bus.ex_valid &&
                      ((bus.ex_pred_taken != taken) || (taken && (bus.ex_pred_target != target)));
  assign update     = bus.ex_valid && is_ctl;
  assign e_idx      = bus.ex_pc[IDXW+1:2];
  assign e_tag      = bus.ex_pc[XLEN-1:IDXW+2];
  assign e_hit      = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  // Jumps always (re)allocate as strongly taken; branches train on hit, allocate only when taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]   <= 1'b0;
        tag_q[i]     <= '0;
        target_q[i]  <= '0;
        is_jump_q[i] <= 1'b0;
        ctr_q[i]     <= 2'b01;
      end
    end else if (update) begin
      if (is_jmp) begin
        valid_q[e_idx]   <= 1'b1;
        tag_q[e_idx]     <= e_tag;
        target_q[e_idx]  <= target;
        is_jump_q[e_idx] <= 1'b1;
        ctr_q[e_idx]     <= 2'b11;
      end else if (e_hit) begin
        if (taken) begin
          target_q[e_idx] <= target;
          if (ctr_q[e_idx] != 2'b11) ctr_q[e_idx] <= ctr_q[e_idx] + 2'b01;
        end else if (ctr_q[e_idx] != 2'b00) begin
          ctr_q[e_idx] <= ctr_q[e_idx] - 2'b01;
        end
      end else if (taken) begin
        valid_q[e_idx]   <= 1'b1;
        tag_q[e_idx]     <= e_tag;
        target_q[e_idx]  <= target;
        is_jump_q[e_idx] <= 1'b0;
        ctr_q[e_idx]     <= 2'b10;
      end
    end
  end

  // redirect_pc keeps the last corrected PC between mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q       <= 1'b0;
      redirect_pc_q    <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      redirect_q <= mispredict;
      if (mispredict) begin
        redirect_pc_q <= taken ? target : bus.ex_pc_plus4;
        if (mispredict_cnt_q != '1) mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.redirect       = redirect_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized scoreboard bench for branch_predict_unit against a slot-ownership BTB model.
// The driver queues expected fetch predictions and redirect state; a monitor compares them.
module tb_branch_predict_unit;
  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 4;
  localparam int IDXW    = $clog2(ENTRIES);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  branch_predict_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    logic [31:0] target;
    bit          jump;
    int          strength;
  } entry_t;

  typedef struct {
    logic        taken;
    logic [31:0] target;
  } pred_exp_t;

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] cnt;
  } red_exp_t;

  entry_t      btb [ENTRIES];
  logic [31:0] exp_rpc;
  int          mis_count;
  pred_exp_t   pred_q[$];
  red_exp_t    red_q[$];
  int          passed;
  int          total;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  function automatic void modelReset();
    for (int i = 0; i < ENTRIES; i++) btb[i] = '{valid: 1'b0, pc: 32'h0, target: 32'h0, jump: 1'b0, strength: 1};
    exp_rpc   = 32'h0;
    mis_count = 0;
  endfunction

  function automatic bit ownsSlot(input logic [31:0] pc);
    int i = int'((pc >> 2) % ENTRIES);
    return btb[i].valid && ((btb[i].pc >> (IDXW + 2)) == (pc >> (IDXW + 2)));
  endfunction

  function automatic void modelPredict(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int i = int'((pc >> 2) % ENTRIES);
    t  = ownsSlot(pc) && (btb[i].jump || btb[i].strength >= 2);
    tg = t ? btb[i].target : 32'h0;
  endfunction

  function automatic void modelResolve(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [31:0] pc, imm, a, b,
                                       output bit tk, output logic [31:0] tgt,
                                       output bit ctl, output bit jmp);
    tk = 0; tgt = 32'h0; ctl = 0; jmp = 0;
    if (op == 7'h63) begin
      tgt = pc + imm;
      ctl = 1;
      case (f3)
        3'd0:    tk = (a == b);
        3'd1:    tk = (a != b);
        3'd4:    tk = (int'(a) <  int'(b));
        3'd5:    tk = (int'(a) >= int'(b));
        3'd6:    tk = (longint'(a) <  longint'(b));
        3'd7:    tk = (longint'(a) >= longint'(b));
        default: ctl = 0;
      endcase
    end else if (op == 7'h6F) begin
      tk = 1; tgt = pc + imm; ctl = 1; jmp = 1;
    end else if (op == 7'h67) begin
      tk = 1; tgt = (a + imm) & 32'hFFFF_FFFE; ctl = 1; jmp = 1;
    end
  endfunction

  function automatic void modelTrain(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input bit jmp);
    int i = int'((pc >> 2) % ENTRIES);
    if (jmp) begin
      btb[i] = '{valid: 1'b1, pc: pc, target: tgt, jump: 1'b1, strength: 3};
    end else if (ownsSlot(pc)) begin
      if (tk) begin
        btb[i].strength = (btb[i].strength < 3) ? btb[i].strength + 1 : 3;
        btb[i].target   = tgt;
      end else begin
        btb[i].strength = (btb[i].strength > 0) ? btb[i].strength - 1 : 0;
      end
    end else if (tk) begin
      btb[i] = '{valid: 1'b1, pc: pc, target: tgt, jump: 1'b0, strength: 2};
    end
  endfunction

  // One cycle of stimulus: drive at the falling edge and queue what the DUT must show.
  task automatic applyStimulus(input bit rst, input logic [31:0] ifpc, input bit v,
                               input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] pc, imm, a, b,
                               input bit ptk, input logic [31:0] ptgt, output bit mis);
    pred_exp_t   pe;
    red_exp_t    re;
    bit          tk, ctl, jmp, pt;
    logic [31:0] tgt, ptg;
    @(negedge clk);
    rst_n              = rst;
    bus.if_pc          = ifpc;
    bus.ex_valid       = v;
    bus.ex_opcode      = op;
    bus.ex_funct3      = f3;
    bus.ex_pc          = pc;
    bus.ex_pc_plus4    = pc + 32'd4;
    bus.ex_imm         = imm;
    bus.ex_srcA        = a;
    bus.ex_srcB        = b;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
    if (!rst) modelReset();
    modelPredict(ifpc, pt, ptg);
    pe.taken  = pt;
    pe.target = ptg;
    pred_q.push_back(pe);
    mis = 0;
    if (rst) begin
      modelResolve(op, f3, pc, imm, a, b, tk, tgt, ctl, jmp);
      mis = v && ((ptk != tk) || (tk && ptgt != tgt));
      if (mis) begin
        exp_rpc = tk ? tgt : pc + 32'd4;
        mis_count++;
      end
      if (v && ctl) modelTrain(pc, tk, tgt, jmp);
    end
    re.redirect = mis;
    re.rpc      = exp_rpc;
    re.cnt      = (mis_count > CNT_MAX) ? CNT_MAX : mis_count;
    red_q.push_back(re);
  endtask

  task automatic applyIdle(input bit rst, input logic [31:0] ifpc);
    bit m;
    applyStimulus(rst, ifpc, 1'b0, 7'h13, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, m);
  endtask

  task automatic applyEx(input logic [31:0] ifpc, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, imm, a, b, input bit ptk, input logic [31:0] ptgt);
    bit m;
    applyStimulus(1'b1, ifpc, 1'b1, op, f3, pc, imm, a, b, ptk, ptgt, m);
  endtask

  // Monitor: prediction mid-low-phase, registered outputs just after the rising edge.
  initial begin
    pred_exp_t p;
    red_exp_t  r;
    forever begin
      @(negedge clk);
      #2;
      if (pred_q.size() > 0) begin
        p = pred_q.pop_front();
        checkOutput("pred_taken", 32'(bus.pred_taken), 32'(p.taken));
        checkOutput("pred_target", bus.pred_target, p.target);
      end
      @(posedge clk);
      #1;
      if (red_q.size() > 0) begin
        r = red_q.pop_front();
        checkOutput("redirect", 32'(bus.redirect), 32'(r.redirect));
        checkOutput("redirect_pc", bus.redirect_pc, r.rpc);
        checkOutput("mispredict_cnt", 32'(bus.mispredict_cnt), r.cnt);
      end
    end
  end

  initial begin
    logic [31:0] vals [6];
    logic [6:0]  ops  [6];
    logic [31:0] pc, ifpc, imm, a, b, ptgt;
    bit          ptk, v, prev;
    passed = 0;
    total  = 0;
    vals = '{32'h0, 32'h1, 32'h5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_1001};
    ops  = '{7'h63, 7'h63, 7'h63, 7'h6F, 7'h67, 7'h33};
    rst_n = 1'b0;
    bus.if_pc = '0; bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ex_pc_plus4 = '0;
    bus.ex_imm = '0; bus.ex_srcA = '0; bus.ex_srcB = '0; bus.ex_funct3 = '0;
    bus.ex_opcode = '0; bus.ex_pred_taken = 1'b0; bus.ex_pred_target = '0;
    modelReset();

    applyIdle(1'b0, 32'h100);
    applyIdle(1'b0, 32'h100);
    applyIdle(1'b1, 32'h100);

    applyEx(32'h100, 7'h63, 3'd0, 32'h100, 32'h40, 32'd5, 32'd5, 1'b0, 32'h0);
    applyIdle(1'b1, 32'h100);
    applyEx(32'h100, 7'h63, 3'd0, 32'h100, 32'h40, 32'd5, 32'd6, 1'b1, 32'h140);
    applyIdle(1'b1, 32'h100);
    applyEx(32'h100, 7'h63, 3'd0, 32'h100, 32'h40, 32'd5, 32'd6, 1'b0, 32'h0);
    applyIdle(1'b1, 32'h100);

    applyEx(32'h200, 7'h67, 3'd0, 32'h200, 32'h4, 32'h1001, 32'h0, 1'b0, 32'h0);
    applyIdle(1'b1, 32'h200);
    applyEx(32'h200, 7'h67, 3'd0, 32'h200, 32'h4, 32'h2001, 32'h0, 1'b1, 32'h1004);
    applyIdle(1'b1, 32'h200);

    applyEx(32'h100, 7'h63, 3'd0, 32'h100, 32'h40, 32'd7, 32'd7, 1'b0, 32'h0);
    applyIdle(1'b1, 32'h100);
    applyEx(32'h100, 7'h63, 3'd0, 32'h100 + 4 * ENTRIES, 32'h8, 32'd7, 32'd7, 1'b0, 32'h0);
    applyIdle(1'b1, 32'h100);

    applyEx(32'h300, 7'h33, 3'd0, 32'h300, 32'h0, 32'h0, 32'h0, 1'b1, 32'h999);
    applyIdle(1'b1, 32'h300);

    for (int k = 0; k < 17; k++) begin
      applyEx(32'h100, 7'h33, 3'd0, 32'h400 + 32'(4 * k), 32'h0, 32'h0, 32'h0, 1'b1, 32'h800);
      applyIdle(1'b1, 32'h100);
    end

    applyEx(32'h200, 7'h6F, 3'd0, 32'h500, 32'h20, 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_redirect", 32'(bus.redirect), 32'h0);
    checkOutput("rst_cnt", 32'(bus.mispredict_cnt), 32'h0);
    checkOutput("rst_redirect_pc", bus.redirect_pc, 32'h0);
    checkOutput("rst_pred_taken", 32'(bus.pred_taken), 32'h0);
    applyIdle(1'b0, 32'h100);
    applyIdle(1'b1, 32'h100);
    applyIdle(1'b1, 32'h500);

    prev = 0;
    for (int n = 0; n < 1500; n++) begin
      pc   = 32'h100 + 32'(4 * $urandom_range(0, 39));
      ifpc = ($urandom_range(0, 3) == 0) ? pc : 32'h100 + 32'(4 * $urandom_range(0, 39));
      if ($urandom_range(0, 299) == 0) begin
        applyIdle(1'b0, ifpc);
        prev = 0;
      end else if (prev) begin
        applyIdle(1'b1, ifpc);
        prev = 0;
      end else begin
        imm = (32'($urandom_range(0, 127)) << 2) - 32'd256;
        if ($urandom_range(0, 1) == 1) imm = imm | 32'h1;
        a = vals[$urandom_range(0, 5)];
        b = vals[$urandom_range(0, 5)];
        if ($urandom_range(0, 1) == 1) begin
          modelPredict(pc, ptk, ptgt);
        end else begin
          ptk  = 1'($urandom_range(0, 1));
          ptgt = ptk ? 32'h100 + 32'(4 * $urandom_range(0, 39)) : 32'h0;
        end
        v = ($urandom_range(0, 7) != 0);
        applyStimulus(1'b1, ifpc, v, ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                      pc, imm, a, b, ptk, ptgt, prev);
      end
    end

    @(posedge clk);
    #3;
    checkOutput("queue_drain", 32'(pred_q.size() + red_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the single-cycle branch resolver for the pipelined core. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, which gives fetch a same-cycle prediction. It resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR in EX and trains the tables. On a mispredict it raises a registered redirect to fetch one cycle after resolution. It also keeps a saturating mispredict counter for performance debug.

## Interface
- XLEN, 32: datapath/PC width.
- ENTRIES, 16: BTB depth; power of two, at least 2. IDXW = log2(ENTRIES).
- CNT_W, 32: width of mispredict_cnt.

- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- if_pc  in  XLEN  fetch PC to predict.
- pred_taken  out  1  fetch prediction (combinational from table state).
- pred_target  out  XLEN  predicted target; 0 when pred_taken=0.
- ex_valid  in  1  EX holds a valid instruction this cycle.
- ex_pc, ex_pc_plus4, ex_imm, ex_srcA, ex_srcB  in  XLEN  EX instruction PC, PC+4, sign-extended immediate, rs1 and rs2 values.
- ex_funct3  in  3  branch condition code.
- ex_opcode  in  7  instruction opcode.
- ex_pred_taken  in  1  prediction made for this instruction at fetch (piped along).
- ex_pred_target  in  XLEN  target predicted at fetch.
- redirect  out  1  registered; fetch must load redirect_pc and flush younger work.
- redirect_pc  out  XLEN  registered corrected PC.
- mispredict_cnt  out  CNT_W  saturating mispredict count.

## Operation
- Index = pc[IDXW+1:2]; tag = pc[XLEN-1:IDXW+2]. Each entry holds valid, tag, target, is_jump and a 2-bit counter.
- Fetch lookup: hit = valid & tag match.
  - pred_taken = hit & (is_jump | ctr[1]).
  - pred_target = entry target when pred_taken=1, else 0.
- Resolution applies only when ex_valid=1:
  - Opcode 1100011 (branch):
    - funct3 000: taken when A==B.
    - 001: taken when A!=B.
    - 100: signed A<B.
    - 101: signed A>=B.
    - 110: unsigned A<B.
    - 111: unsigned A>=B.
    - 010/011: not taken, and no table update.
    - Target = ex_pc + ex_imm.
  - Opcode 1101111 (JAL): taken; target = ex_pc + ex_imm.
  - Opcode 1100111 (JALR): taken; target = (ex_srcA + ex_imm) with bit0 cleared.
  - Any other opcode: not taken; no table update.
  - All adds are modulo 2^XLEN.
- Mispredict = ex_valid & ((ex_pred_taken != taken) | (taken & ex_pred_target != target)).
  - Applies to non-control opcodes as well: a stale predicted-taken alias is corrected.
- Table update at the clock edge, for a valid control instruction:
  - Branch, entry hit: counter saturating +1 if taken, -1 if not; target overwritten when taken.
  - Branch miss, taken: allocate with valid=1, new tag, target, is_jump=0, ctr=10.
  - Branch miss, not taken: no allocation.
  - JAL/JALR: allocate or overwrite with is_jump=1, ctr=11, target.
- Redirect register, at each edge:
  - redirect <= mispredict.
  - redirect_pc <= taken ? target : ex_pc_plus4, loaded only when mispredict=1; otherwise it holds its value.
- mispredict_cnt increments on each mispredict and saturates at all-ones.

## Timing
- Reset values:
  - Every valid bit = 0, every counter = 01, targets and tags = 0.
  - redirect = 0, redirect_pc = 0, mispredict_cnt = 0.
  - pred_taken = 0 and pred_target = 0 while in reset.
- Prediction latency: 0 cycles (combinational from if_pc).
- Training becomes visible to fetch lookups starting the cycle after the resolving edge.
- Same-cycle lookup and update on the same index: the lookup returns the old entry.
- Redirect latency: redirect is high exactly one cycle after the EX cycle that mispredicted. The block never holds redirect high on its own.
- Back-to-back mispredicts give back-to-back redirect pulses, each carrying its own redirect_pc.
- The bench drops ex_valid in the cycle redirect is high (the pipeline flush). The block does not check this.
- Reset asserted mid-operation: all state clears immediately (asynchronous). The first update is possible on the first rising edge after rst_n deasserts.
- ex_valid=0: no update, redirect <= 0, counter holds.

## Test plan
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0, redirect=0, mispredict_cnt=0.
- BEQ at 0x100, A=B=5, imm=0x40, predicted not taken -> next cycle redirect=1, redirect_pc=0x140, cnt=1.
  - Then if_pc=0x100 -> pred_taken=1 (ctr=10), pred_target=0x140.
- Same BEQ with A=5, B=6, predicted taken to 0x140 -> redirect_pc=0x104, ctr=01, then pred_taken=0.
  - Second not-taken resolution -> ctr=00, no redirect.
- JALR at 0x200, srcA=0x1001, imm=4, predicted not taken -> redirect_pc=0x1004.
  - Later prediction hit to 0x1004 (is_jump=1).
  - Repeat with srcA=0x2001 while predicting 0x1004 -> redirect_pc=0x2004.
- Aliasing: taken branch at 0x100 then one at 0x100 + 4*ENTRIES -> second overwrites tag; if_pc=0x100 -> pred_taken=0.
  - Non-control instruction arriving with ex_pred_taken=1 -> redirect_pc=ex_pc_plus4.
- Force CNT_W=4 and give 17 mispredicts -> mispredict_cnt stays at 0xF.
  - Assert rst_n=0 mid-redirect -> redirect drops immediately and all entries are invalid.
